i2c_tmp10x_reader: RTL and testbench
====================================

I2C_TMP10X_READER -- requirements
Module: i2c_tmp10x_reader

Interface
REQ-001 The module SHALL have parameter ADDRESSLENGTH, default 7, giving the slave address width in bits.
REQ-002 The module SHALL have parameter NBYTES, default 2, giving the number of data bytes read per transaction.
REQ-003 The module SHALL have parameter CLKDIV, default 4, giving the CLK cycles per SCL quarter-period (legal range 1..255).
REQ-004 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-005 RSTn  input  1  asynchronous active-low reset.
REQ-006 REQ  input  1  transaction request, sampled only in IDLE.
REQ-007 SLAVEADDR  input  ADDRESSLENGTH  target address, captured when REQ is accepted.
REQ-008 POINTER  input  8  register pointer byte, captured when REQ is accepted.
REQ-009 SCL_OE  output  1  1 = pull SCL low, 0 = release SCL.
REQ-010 SDA_OE  output  1  1 = pull SDA low, 0 = release SDA.
REQ-011 SDA_IN  input  1  sampled SDA line level.
REQ-012 BUSY  output  1  high from the cycle after REQ acceptance until DONE.
REQ-013 DONE  output  1  one-cycle completion pulse.
REQ-014 NACK_ERR  output  1  status of the last transaction; valid from DONE until the next acceptance.
REQ-015 Data  output  8*NBYTES  bytes read, first byte in the MSBs.

Function
REQ-016 The transaction SHALL be: START, address+W, ACK, POINTER, ACK, repeated START, address+R, ACK, NBYTES bytes read, STOP.
- Master ACKs every read byte except the last, which gets NACK.
- Bits are sent MSB first.
REQ-017 A sub-module SHALL pulse a quarter tick every CLKDIV cycles while BUSY; every phase SHALL last 4 quarters (q0..q3).
REQ-018 Bit phase: SCL low during q0 and q3, released during q1 and q2.
- SDA changes only at q0 start.
- SDA_IN is sampled at the end of q2.
REQ-019 START phase: both lines released in q0-q1, SDA low from q2, SCL low from q3.
REQ-020 Repeated START phase: SCL low with SDA released in q0, SCL released in q1, SDA low in q2, SCL low in q3.
REQ-021 STOP phase: SCL low with SDA low in q0, SCL released in q1, SDA released in q2, both released in q3.
REQ-022 State machine states and transitions:
- States: IDLE, START, ADDR_W, ACK_AW, PTR, ACK_P, RSTART, ADDR_R, ACK_AR, RDBYTE, MACK, STOP.
- Order: IDLE->START->ADDR_W->ACK_AW->PTR->ACK_P->RSTART->ADDR_R->ACK_AR->(RDBYTE->MACK) x NBYTES->STOP->IDLE.
REQ-023 A sampled SDA_IN=1 in any ACK_* state SHALL transition to STOP; the resulting DONE carries NACK_ERR=1 and Data is left unchanged.
REQ-024 A successful transaction SHALL update Data on DONE and clear NACK_ERR.
REQ-025 DONE SHALL pulse exactly 4*CLKDIV*(30+9*NBYTES) cycles after the REQ-sampling edge; with defaults this is 768 cycles.
REQ-026 Simultaneous events:
- REQ while BUSY is ignored.
- REQ held high through DONE starts a new transaction on the cycle after DONE.
REQ-027 A byte counter SHALL count 0..NBYTES-1 and wrap to 0 in STOP.

Reset
REQ-028 RSTn low SHALL asynchronously force:
- state=IDLE, SCL_OE=0, SDA_OE=0;
- BUSY=0, DONE=0, NACK_ERR=0, Data=0;
- tick counter, bit counter and byte counter to 0.
REQ-029 Reset asserted mid-transaction SHALL release both lines immediately without generating STOP; after release, the module SHALL wait in IDLE for REQ.

Structure
REQ-030 The state encoding and the phase/quarter constants SHALL live in shared package i2c_pkg, alongside the slave-side definitions.
REQ-031 The quarter-tick divider SHALL be sub-module i2c_tick_gen (ports CLK, RSTn, EN, TICK).

Verification
REQ-032 Defaults, slave model at 0x48 returning 0x19,0x80, REQ with SLAVEADDR=0x48 and POINTER=0x00 -> the bench checks:
- bytes 0x90, 0x00, 0x91 on the bus;
- master ACK after 0x19, NACK after 0x80;
- Data=0x1980, NACK_ERR=0, DONE at cycle 768.
REQ-033 SLAVEADDR=0x49 with no responding slave -> NACK in ACK_AW, then STOP, DONE with NACK_ERR=1, Data unchanged, DONE at 4*CLKDIV*11 cycles.
REQ-034 RSTn pulsed low during RDBYTE -> SCL_OE=SDA_OE=0 within the same cycle, BUSY=0, Data=0; a subsequent REQ completes normally.
REQ-035 REQ held high continuously -> back-to-back transactions, one DONE per transaction, no REQ sampled while BUSY.
REQ-036 NBYTES=1, CLKDIV=1 -> single byte read with NACK, DONE at 156 cycles.
REQ-037 An assertion SHALL check across all scenarios that SDA_OE changes while SCL is released only in START, RSTART and STOP phases.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM encoding, quarter-phase constants and
// the bus-level constants a slave implementation also needs.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_AW, PTR, ACK_P,
        RSTART, ADDR_R, ACK_AR, RDBYTE, MACK, STOP
    } state_e;

    typedef logic [1:0] qtr_t;
    localparam qtr_t Q0 = 2'd0;
    localparam qtr_t Q1 = 2'd1;
    localparam qtr_t Q2 = 2'd2;
    localparam qtr_t Q3 = 2'd3;
    localparam int   QTR_PER_PHASE = 4;

    // Slave-side view of the bus
    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {SLV_IDLE, SLV_ADDR, SLV_RX, SLV_TX} slv_state_e;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period strobe: one-cycle TICK every CLKDIV cycles while EN is high,
// restarting from zero whenever EN drops.
module i2c_tick_gen #(
    parameter int CLKDIV = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic EN,
    output logic TICK
);

    logic [7:0] cnt_q, cnt_d;

    assign TICK = EN && (cnt_q == 8'(CLKDIV - 1));

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (!EN || TICK) cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_tmp10x_reader.sv
// I2C master that sets a register pointer and reads NBYTES back
// (TMP10x-style temperature sensor access) over open-drain SCL/SDA.
module i2c_tmp10x_reader
    import i2c_pkg::*;
#(
    parameter int ADDRESSLENGTH = 7,
    parameter int NBYTES        = 2,
    parameter int CLKDIV        = 4
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     REQ,
    input  logic [ADDRESSLENGTH-1:0] SLAVEADDR,
    input  logic [7:0]               POINTER,
    output logic                     SCL_OE,
    output logic                     SDA_OE,
    input  logic                     SDA_IN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     NACK_ERR,
    output logic [8*NBYTES-1:0]      Data
);

    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_e                   state_q, state_d;
    qtr_t                     qtr_q, qtr_d;
    logic [2:0]               bit_q, bit_d;
    logic [BW-1:0]            byte_q, byte_d;
    logic                     samp_q, samp_d;
    logic                     err_q, err_d;
    logic [ADDRESSLENGTH-1:0] addr_q, addr_d;
    logic [7:0]               ptr_q, ptr_d;
    logic [8*NBYTES-1:0]      rx_q, rx_d;
    logic [8*NBYTES-1:0]      data_q, data_d;
    logic                     nack_q, nack_d;
    logic                     done_q, done_d;

    logic       tick;
    logic [7:0] tx_byte;
    logic       tx_bit;
    logic       last_byte;

    assign BUSY     = (state_q != IDLE);
    assign DONE     = done_q;
    assign NACK_ERR = nack_q;
    assign Data     = data_q;

    i2c_tick_gen #(.CLKDIV(CLKDIV)) u_tick (
        .CLK  (CLK),
        .RSTn (RSTn),
        .EN   (BUSY),
        .TICK (tick)
    );

    always_comb begin
        tx_byte = ptr_q;
        case (state_q)
            ADDR_W:  tx_byte = addr_byte(7'(addr_q), RW_WRITE);
            ADDR_R:  tx_byte = addr_byte(7'(addr_q), RW_READ);
            default: ;
        endcase
    end

    assign tx_bit    = tx_byte[3'd7 - bit_q];
    assign last_byte = (byte_q == BW'(NBYTES - 1));

    // Line drive is decoded from registered state, so SDA only moves at q0
    // in bit phases and reset releases both lines without a clock edge.
    always_comb begin
        SCL_OE = 1'b0;
        SDA_OE = 1'b0;
        case (state_q)
            IDLE: ;
            START: begin
                SCL_OE = (qtr_q == Q3);
                SDA_OE = (qtr_q == Q2) || (qtr_q == Q3);
            end
            RSTART: begin
                SCL_OE = (qtr_q == Q0) || (qtr_q == Q3);
                SDA_OE = (qtr_q == Q2) || (qtr_q == Q3);
            end
            STOP: begin
                SCL_OE = (qtr_q == Q0);
                SDA_OE = (qtr_q == Q0) || (qtr_q == Q1);
            end
            default: begin
                SCL_OE = (qtr_q == Q0) || (qtr_q == Q3);
                case (state_q)
                    ADDR_W, PTR, ADDR_R: SDA_OE = ~tx_bit;
                    MACK:                SDA_OE = last_byte ? ~BIT_NACK : ~BIT_ACK;
                    default:             ;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        samp_d  = samp_q;
        err_d   = err_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        rx_d    = rx_q;
        data_d  = data_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (REQ) begin
                state_d = START;
                qtr_d   = Q0;
                bit_d   = '0;
                byte_d  = '0;
                err_d   = 1'b0;
                addr_d  = SLAVEADDR;
                ptr_d   = POINTER;
            end
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == Q2) begin
                samp_d = SDA_IN;
                if (state_q == RDBYTE) rx_d = {rx_q[8*NBYTES-2:0], SDA_IN};
            end
            if (qtr_q == Q3) begin
                case (state_q)
                    START:  state_d = ADDR_W;
                    RSTART: state_d = ADDR_R;
                    ADDR_W, PTR, ADDR_R, RDBYTE: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            case (state_q)
                                ADDR_W:  state_d = ACK_AW;
                                PTR:     state_d = ACK_P;
                                ADDR_R:  state_d = ACK_AR;
                                default: state_d = MACK;
                            endcase
                        end
                    end
                    ACK_AW, ACK_P, ACK_AR: begin
                        if (samp_q == BIT_NACK) begin
                            state_d = STOP;
                            err_d   = 1'b1;
                        end else begin
                            case (state_q)
                                ACK_AW:  state_d = PTR;
                                ACK_P:   state_d = RSTART;
                                default: state_d = RDBYTE;
                            endcase
                        end
                    end
                    MACK: begin
                        if (last_byte) begin
                            state_d = STOP;
                        end else begin
                            state_d = RDBYTE;
                            byte_d  = byte_q + BW'(1);
                        end
                    end
                    STOP: begin
                        state_d = IDLE;
                        byte_d  = '0;
                        done_d  = 1'b1;
                        nack_d  = err_q;
                        if (!err_q) data_d = rx_q;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            qtr_q   <= Q0;
            bit_q   <= '0;
            byte_q  <= '0;
            samp_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            ptr_q   <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            samp_q  <= samp_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_i2c_tmp10x_reader.sv
// Directed bench: two readers (default and NBYTES=1/CLKDIV=1) share one
// open-drain bus with a sensor model at 0x48 that returns 0x19, 0x80.
module tb_i2c_tmp10x_reader;
    import i2c_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        REQ0 = 1'b0, REQ1 = 1'b0;
    logic [6:0]  SLAVEADDR = 7'h48;
    logic [7:0]  POINTER = 8'h00;
    logic        SDA_IN;
    logic        scl0, sda0, busy0, done0, nack0;
    logic        scl1, sda1, busy1, done1, nack1;
    logic [15:0] data0;
    logic [7:0]  data1;
    logic        s_oe = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    wire scl_l = !(scl0 | scl1);
    wire sda_l = !(sda0 | sda1 | s_oe);
    assign SDA_IN = sda_l;

    always #5 CLK = ~CLK;

    i2c_tmp10x_reader dut0 (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ0), .SLAVEADDR(SLAVEADDR), .POINTER(POINTER),
        .SCL_OE(scl0), .SDA_OE(sda0), .SDA_IN(SDA_IN), .BUSY(busy0), .DONE(done0),
        .NACK_ERR(nack0), .Data(data0)
    );

    i2c_tmp10x_reader #(.NBYTES(1), .CLKDIV(1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ1), .SLAVEADDR(SLAVEADDR), .POINTER(POINTER),
        .SCL_OE(scl1), .SDA_OE(sda1), .SDA_IN(SDA_IN), .BUSY(busy1), .DONE(done1),
        .NACK_ERR(nack1), .Data(data1)
    );

    // Sensor model plus frame log (byte and its 9th-clock bit)
    logic [7:0] rdat [2] = '{8'h19, 8'h80};
    logic [7:0] mon_b [$];
    logic       mon_a [$];
    logic       p_scl = 1'b1, p_sda = 1'b1, act = 1'b0, sel = 1'b0, rd = 1'b0;
    logic [7:0] sh = '0;
    int         bcnt = 0, fidx = 0, ridx = 0;

    always @(negedge CLK) begin
        logic cs, cd;
        cs = scl_l;
        cd = sda_l;
        if (!RSTn) begin
            s_oe = 1'b0; act = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
        end else begin
            if (p_scl && cs && p_sda && !cd) begin
                act = 1'b1; bcnt = 0; fidx = 0; rd = 1'b0;
            end else if (p_scl && cs && !p_sda && cd) begin
                act = 1'b0; s_oe = 1'b0;
            end else if (act && !p_scl && cs) begin
                if (bcnt < 8) sh = {sh[6:0], cd};
                bcnt++;
                if (bcnt == 9) begin
                    mon_b.push_back(sh);
                    mon_a.push_back(cd);
                    if (fidx == 0) begin
                        sel = (sh[7:1] == 7'h48); rd = sel && sh[0]; ridx = 0;
                    end else if (rd) begin
                        if (cd) rd = 1'b0; else ridx++;
                    end
                    fidx++;
                    bcnt = 0;
                end
            end else if (act && p_scl && !cs) begin
                if (bcnt == 8)  s_oe = !rd && ((fidx == 0) ? (sh[7:1] == 7'h48) : sel);
                else if (rd)    s_oe = !rdat[ridx % 2][7 - bcnt];
                else            s_oe = 1'b0;
            end
            p_scl = cs;
            p_sda = cd;
        end
    end

    // SDA may only move under a released SCL in START/RSTART/STOP phases
    logic ps0 = 1'b0, pd0 = 1'b0, ps1 = 1'b0, pd1 = 1'b0, pr = 1'b0;
    always @(negedge CLK) begin
        if (RSTn && pr && !scl0 && !ps0 && (sda0 !== pd0)) begin
            n_assert++;
            assert (dut0.state_q inside {START, RSTART, STOP}) else begin
                n_fail++;
                $error("FAIL sda_under_scl_high0: state %0d, required START/RSTART/STOP", dut0.state_q);
            end
        end
        if (RSTn && pr && !scl1 && !ps1 && (sda1 !== pd1)) begin
            n_assert++;
            assert (dut1.state_q inside {START, RSTART, STOP}) else begin
                n_fail++;
                $error("FAIL sda_under_scl_high1: state %0d, required START/RSTART/STOP", dut1.state_q);
            end
        end
        ps0 = scl0; pd0 = sda0; ps1 = scl1; pd1 = sda1; pr = RSTn;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and count cycles from the sampling edge to DONE
    task automatic run(input bit which, output int cyc);
        if (which) REQ1 = 1'b1; else REQ0 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        cyc = 0;
        while (!(which ? done1 : done0) && cyc < 3000) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
        end
    endtask

    task automatic chk_frames(input string tag, input int n, input logic [7:0] eb [5],
                              input logic ea [5]);
        chk({tag, "_nframes"}, mon_b.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), (i < mon_b.size()) ? mon_b[i] : 8'hxx, eb[i]);
            chk($sformatf("%s_ack%0d", tag, i), (i < mon_a.size()) ? mon_a[i] : 1'bx, ea[i]);
        end
    endtask

    initial begin
        int         cyc;
        int         ndone;
        int         tdone [2];
        logic [7:0] eb [5];
        logic       ea [5];

        repeat (3) @(negedge CLK);
        chk("rst_scl", scl0, 0);
        chk("rst_sda", sda0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_nack", nack0, 0);
        chk("rst_data", data0, 0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Normal two-byte read
        mon_b.delete(); mon_a.delete();
        run(1'b0, cyc);
        chk("t1_cycles", cyc, 768);
        chk("t1_data", data0, 16'h1980);
        chk("t1_nack", nack0, 0);
        chk("t1_busy_at_done", busy0, 0);
        eb = '{8'h90, 8'h00, 8'h91, 8'h19, 8'h80};
        ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        chk_frames("t1", 5, eb, ea);
        @(negedge CLK);
        chk("t1_done_pulse", done0, 0);

        // Nobody answers at 0x49
        SLAVEADDR = 7'h49;
        mon_b.delete(); mon_a.delete();
        run(1'b0, cyc);
        chk("t2_cycles", cyc, 176);
        chk("t2_nack", nack0, 1);
        chk("t2_data_kept", data0, 16'h1980);
        eb = '{8'h92, 8'h00, 8'h00, 8'h00, 8'h00};
        ea = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        chk_frames("t2", 1, eb, ea);
        SLAVEADDR = 7'h48;
        @(negedge CLK);

        // Reset in RDBYTE (bit 2, q0: SCL held low)
        REQ0 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ0 = 1'b0;
        repeat (497) @(posedge CLK);
        #1;
        chk("t3_scl_pre", scl0, 1);
        chk("t3_busy_pre", busy0, 1);
        RSTn = 1'b0;
        #1;
        chk("t3_scl", scl0, 0);
        chk("t3_sda", sda0, 0);
        chk("t3_busy", busy0, 0);
        chk("t3_data", data0, 0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        mon_b.delete(); mon_a.delete();
        run(1'b0, cyc);
        chk("t3_after_cycles", cyc, 768);
        chk("t3_after_data", data0, 16'h1980);
        chk("t3_after_nack", nack0, 0);
        @(negedge CLK);

        // REQ held high: back-to-back with one idle cycle between
        REQ0 = 1'b1;
        @(posedge CLK);
        ndone = 0;
        tdone = '{0, 0};
        for (int c = 1; c <= 1537; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (done0) begin
                if (ndone < 2) tdone[ndone] = c;
                ndone++;
            end
        end
        REQ0 = 1'b0;
        chk("t4_ndone", ndone, 2);
        chk("t4_first", tdone[0], 768);
        chk("t4_second", tdone[1], 1537);
        chk("t4_data", data0, 16'h1980);
        repeat (3) @(negedge CLK);
        chk("t4_no_extra", busy0, 0);

        // Single-byte reader at CLKDIV=1
        mon_b.delete(); mon_a.delete();
        run(1'b1, cyc);
        chk("t5_cycles", cyc, 156);
        chk("t5_data", data1, 8'h19);
        chk("t5_nack", nack1, 0);
        eb = '{8'h90, 8'h00, 8'h91, 8'h19, 8'h00};
        ea = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        chk_frames("t5", 4, eb, ea);
        repeat (4) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
